sc_io_hex_display: RTL and testbench

//  Output-port consumer for the single-cycle computer. Takes the 32-bit word the

---
 rtl/sc_io_hex_display_pkg.sv | 43 ++++
 rtl/sc_io_hex_display_seg7_decoder.sv | 15 +
 rtl/sc_io_hex_display.sv | 152 +++++++++++++++
 tb/tb_sc_io_hex_display.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sc_io_hex_display_pkg.sv
// Shared definitions for the HEX display consumer: FSM states and segment codes.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package sc_io_hex_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Active-low segment codes, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // BCD digit to segment pattern; non-decimal codes render blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/sc_io_hex_display_seg7_decoder.sv
// Purpose: one BCD digit to an active-low gfedcba 7-segment pattern.
// Latency: combinational. Backpressure: none.
// Ports: bcd (4-bit digit in), seg (7-bit active-low segments out).
module sc_io_hex_display_seg7_decoder
  import sc_io_hex_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_encode(bcd);
  end

endmodule

// File: rtl/sc_io_hex_display.sv
// Purpose: converts the CPU output-port word to decimal (shift-add-3) and drives HEX displays.
// Latency: 33 clocks capture->upd in range, 1 clock on overflow. Backpressure: none;
//          input changes seen mid-conversion are picked up at the next IDLE (newest value wins).
// Ports: clock, resetn (async active-low), value[31:0] in; hex[7*DIGITS-1:0] (digit k at
//        [7k+6:7k], active-low gfedcba), busy, upd (one-cycle update pulse), ovf out.
module sc_io_hex_display
  import sc_io_hex_display_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter bit LZB    = 1'b1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [31:0]           value,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  upd,
  output logic                  ovf
);

  localparam int          BW  = 4 * DIGITS;
  localparam logic [31:0] MAX = 32'(10 ** DIGITS - 1);

  state_t             state_q, state_d;
  logic [31:0]        sh_q, sh_d;
  logic [31:0]        last_q, last_d;
  logic               first_q, first_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [7*DIGITS-1:0] hex_d;
  logic               busy_d, upd_d, ovf_d;

  logic [BW-1:0]       bcd_adj;
  logic [7*DIGITS-1:0] disp;

  // Add-3 correction applied to every digit before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Per-digit decode plus leading-zero blanking. A digit is blanked when it and
  // every digit above it are zero; digit 0 always shows.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      logic [6:0] seg;
      logic       upper_zero;
      logic       blank;

      sc_io_hex_display_seg7_decoder u_dec (
        .bcd (bcd_q[4*g +: 4]),
        .seg (seg)
      );

      assign upper_zero = (bcd_q[BW-1:4*g] == '0);
      if (g == 0) begin : g_lsd
        assign blank = 1'b0;
      end else begin : g_upper
        assign blank = LZB && upper_zero;
      end
      assign disp[7*g +: 7] = blank ? SEG_BLANK : seg;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    last_d     = last_q;
    first_d    = first_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    hex_d      = hex;
    ovf_d      = ovf;
    upd_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (first_q || (value != last_q)) begin
          sh_d    = value;
          last_d  = value;
          first_d = 1'b0;
          bcd_d   = '0;
          cnt_d   = '0;
          if (value > MAX) begin
            ovf_pend_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            ovf_pend_d = 1'b0;
            state_d    = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        {bcd_d, sh_d} = {bcd_adj[BW-2:0], sh_q, 1'b0};
        // A digit carried out of the top would mean a wrong display; treat it
        // as overflow. Unreachable for value <= MAX.
        ovf_pend_d = ovf_pend_q | bcd_adj[BW-1];
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        hex_d   = ovf_pend_q ? {DIGITS{SEG_DASH}} : disp;
        ovf_d   = ovf_pend_q;
        upd_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      last_q     <= '0;
      first_q    <= 1'b1;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      hex        <= {DIGITS{SEG_BLANK}};
      busy       <= 1'b0;
      upd        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      last_q     <= last_d;
      first_q    <= first_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      hex        <= hex_d;
      busy       <= busy_d;
      upd        <= upd_d;
      ovf        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sc_io_hex_display.sv
// Directed bench for sc_io_hex_display: one instance with blanking, one without.
module tb_sc_io_hex_display;

  logic        clock;
  logic        resetn;
  logic [31:0] value;
  logic [41:0] hex;
  logic        busy, upd, ovf;
  logic [31:0] value_nz;
  logic [41:0] hex_nz;
  logic        busy_nz, upd_nz, ovf_nz;

  int n_tests = 0;
  int n_fail  = 0;

  sc_io_hex_display #(.DIGITS(6), .LZB(1'b1)) dut (
    .clock  (clock),
    .resetn (resetn),
    .value  (value),
    .hex    (hex),
    .busy   (busy),
    .upd    (upd),
    .ovf    (ovf)
  );

  sc_io_hex_display #(.DIGITS(6), .LZB(1'b0)) dut_nz (
    .clock  (clock),
    .resetn (resetn),
    .value  (value_nz),
    .hex    (hex_nz),
    .busy   (busy_nz),
    .upd    (upd_nz),
    .ovf    (ovf_nz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts edges until upd rises (bounded). busy_ok drops if busy is low
  // before upd or still high in the upd cycle.
  task automatic wait_upd(input bit sel, output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (n < 200) begin
      tick();
      n++;
      if (sel ? upd_nz : upd) begin
        if (sel ? busy_nz : busy) busy_ok = 1'b0;
        break;
      end else if (!(sel ? busy_nz : busy)) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic count_upd(input bit sel, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (sel ? upd_nz : upd) cnt++;
    end
  endtask

  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [41:0] ALL_DASH  = {6{7'h3F}};

  initial begin
    int n;
    bit ok;
    int c;

    // 1. Power-up and first conversion of 0
    resetn   = 1'b0;
    value    = 32'd0;
    value_nz = 32'd0;
    repeat (3) tick();
    chk("rst hex", hex, ALL_BLANK);
    chk("rst busy", busy, 0);
    chk("rst upd", upd, 0);
    chk("rst ovf", ovf, 0);
    chk("rst hex_nz", hex_nz, ALL_BLANK);
    resetn = 1'b1;
    wait_upd(0, n, ok);
    chk("t1 latency", n, 34);
    chk("t1 busy", ok, 1);
    chk("t1 hex", hex, {{5{7'h7F}}, 7'h40});
    chk("t1 ovf", ovf, 0);

    // 2. In-range conversion
    value = 32'd123456;
    wait_upd(0, n, ok);
    chk("t2 latency", n, 34);
    chk("t2 busy", ok, 1);
    chk("t2 hex", hex, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    chk("t2 ovf", ovf, 0);

    // 3. Boundaries
    value = 32'd999999;
    wait_upd(0, n, ok);
    chk("t3 max latency", n, 34);
    chk("t3 max hex", hex, {6{7'h10}});
    chk("t3 max ovf", ovf, 0);

    value = 32'd1000000;
    wait_upd(0, n, ok);
    chk("t3 ovf latency", n, 2);
    chk("t3 ovf busy", ok, 1);
    chk("t3 ovf hex", hex, ALL_DASH);
    chk("t3 ovf flag", ovf, 1);

    value = 32'hFFFF_FFFF;
    wait_upd(0, n, ok);
    chk("t3 ffff latency", n, 2);
    chk("t3 ffff hex", hex, ALL_DASH);
    chk("t3 ffff ovf", ovf, 1);

    // 4. Change during SHIFT: old value completes, new one follows
    value = 32'd10;
    repeat (5) tick();
    chk("t4 busy mid", busy, 1);
    value = 32'd20;
    wait_upd(0, n, ok);
    chk("t4 first latency", n, 29);
    chk("t4 first hex", hex, {{4{7'h7F}}, 7'h79, 7'h40});
    chk("t4 first ovf", ovf, 0);
    wait_upd(0, n, ok);
    chk("t4 second latency", n, 34);
    chk("t4 second hex", hex, {{4{7'h7F}}, 7'h24, 7'h40});
    count_upd(0, 50, c);
    chk("t4 extra upd", c, 0);
    chk("t4 hex hold", hex, {{4{7'h7F}}, 7'h24, 7'h40});

    // 5. Asynchronous reset mid-conversion
    value = 32'd55;
    repeat (10) tick();
    chk("t5 busy pre", busy, 1);
    resetn = 1'b0;
    #1;
    chk("t5 async hex", hex, ALL_BLANK);
    chk("t5 async busy", busy, 0);
    chk("t5 async upd", upd, 0);
    repeat (2) tick();
    resetn = 1'b1;
    wait_upd(0, n, ok);
    chk("t5 reconv latency", n, 34);
    chk("t5 reconv hex", hex, {{4{7'h7F}}, 7'h12, 7'h12});

    // 6. No blanking instance
    value_nz = 32'd7;
    wait_upd(1, n, ok);
    chk("t6 latency", n, 34);
    chk("t6 busy", ok, 1);
    chk("t6 hex", hex_nz, {{5{7'h40}}, 7'h78});
    chk("t6 ovf", ovf_nz, 0);
    count_upd(1, 100, c);
    chk("t6 stable upd", c, 0);
    chk("t6 hex hold", hex_nz, {{5{7'h40}}, 7'h78});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
